id_ex_forward_stage: RTL and testbench
======================================

// Module: id_ex_forward_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
//  Captures decoded operands/control from ID each cycle and drives the ALU inputs rd1, rd2, sel.
//  Operands are forwarded from EX/MEM and MEM/WB.
//  Inserts a single bubble and stalls IF/ID on a load-use hazard.
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  XLEN   32  datapath width
//  REGW   5   register index width
//  CNTW   16  stall counter width (saturating)
// PORTS
//  clk              in   1     rising-edge clock
//  reset            in   1     synchronous, active-high
//  id_valid         in   1     ID holds a valid instruction
//  id_rs1, id_rs2   in   REGW  source register indices
//  id_rd            in   REGW  destination register index
//  id_rs1_val       in   XLEN  register file read data, rs1
//  id_rs2_val       in   XLEN  register file read data, rs2
//  id_imm           in   XLEN  sign-extended immediate
//  id_alu_sel       in   4     ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//  id_alu_src       in   1     1: ALU operand B = imm; 0: operand B = rs2
//  id_reg_write     in   1     control bit
//  id_mem_read      in   1     control bit
//  id_mem_write     in   1     control bit
//  flush            in   1     kill the instruction entering EX (branch redirect)
//  exmem_rd         in   REGW  EX/MEM destination register
//  exmem_reg_write  in   1     EX/MEM writes a register
//  exmem_result     in   XLEN  EX/MEM ALU result
//  memwb_rd         in   REGW  MEM/WB destination register
//  memwb_reg_write  in   1     MEM/WB writes a register
//  memwb_result     in   XLEN  MEM/WB writeback value
//  stall            out  1     hold PC and IF/ID this cycle
//  ex_valid         out  1     EX holds a valid instruction
//  rd1, rd2         out  XLEN  ALU operands
//  sel              out  4     ALU select
//  ex_store_data    out  XLEN  forwarded rs2 value, for stores
//  ex_rd            out  REGW  registered destination register
//  ex_reg_write     out  1     registered control bit
//  ex_mem_read      out  1     registered control bit
//  ex_mem_write     out  1     registered control bit
//  stall_count      out  CNTW  number of cycles with stall=1
// BEHAVIOUR
//  Reset (sync, wins over everything):
//   - all ID/EX registers clear to 0, so ex_valid=0, sel=0000, ex_rd=0 and all control bits 0.
//   - stall_count=0.
//  Hazard detection (combinational):
//   - haz = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//   - stall = haz & ~flush.
//  Register update on each clk edge (no reset):
//   - flush | stall: load a bubble (valid=0, reg_write/mem_read/mem_write=0, sel=0000, rd=0, operands 0).
//   - otherwise: capture all id_* fields; ex_valid <= id_valid.
//  Latency: id_* values appear on ex_* outputs exactly 1 cycle later.
//  Stall behaviour:
//   - A load-use stall lasts exactly 1 cycle: the bubble clears haz on the next cycle.
//   - Upstream holds id_* stable during a stall.
//  Forwarding (combinational from the registered rs indices/values):
//   - fwdA = registered rs1 value by default.
//   - fwdA = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1.
//   - Otherwise fwdA = memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs1.
//   - EX/MEM has priority over MEM/WB. x0 is never forwarded. fwdB is formed the same way from rs2.
//   - rd1 = fwdA; rd2 = ex_alu_src ? ex_imm : fwdB; ex_store_data = fwdB.
//   - sel passes the registered ALU select straight through.
//  Bubble: rd1=rd2=0, sel=0000.
//  stall_count:
//   - Increments on every edge where stall=1.
//   - Saturates at 2^CNTW-1 with no wrap.
//   - Cleared only by reset.
//  Simultaneous events:
//   - reset > flush > stall.
//   - flush with haz: stall=0, bubble loaded, counter not incremented.
// TESTING
//  T1: id rs1_val=122, rs2_val=100, sel=0010, alu_src=0, no forwarding matches
//      -> next cycle rd1=122, rd2=100, sel=0010, ex_valid=1.
//  T2: ex_rs1=5; exmem_rd=5 (reg_write=1, result=50); memwb_rd=5 (result=75)
//      -> rd1=50. Then drop exmem_reg_write -> rd1=75. Then set both rd=0 -> no forward.
//  T3: EX holds load to x7 while ID holds rs2=7
//      -> stall=1 for exactly 1 cycle, next EX is a bubble (ex_valid=0), stall_count 0->1.
//      Then the instruction issues with forwarded memwb_result.
//  T4: flush=1 with a valid ID instruction and a pending haz
//      -> stall=0, next cycle ex_valid=0 and all control bits 0, stall_count unchanged.
//  T5: alu_src=1, imm=32'hFFFF_FFE7, ex_rs2 forwarded 128
//      -> rd2=32'hFFFF_FFE7, ex_store_data=128.
//  T6: reset asserted mid-stall -> next edge: all outputs 0 and stall_count=0.
//      Also force stall for 2^CNTW+3 cycles (CNTW=4) -> count holds at 15.

Source files
------------

// File: rtl/id_ex_forward_stage.sv
// id_ex_forward_stage: ID/EX pipeline register with EX operand forwarding and load-use stall
module id_ex_forward_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [3:0]      sel,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [CNTW-1:0] stall_count
);
  logic            r_valid;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_sel;
  logic            r_alu_src;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [CNTW-1:0] r_cnt;
  logic            w_haz;
  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  // Load in EX whose destination feeds the instruction in ID; a flush overrides the stall
  always_comb begin
    w_haz = r_valid && r_mem_read && (r_rd != '0) && id_valid && (r_rd == id_rs1 || r_rd == id_rs2);
    stall = w_haz && !flush;
  end
  // Pick the youngest producer of each EX source; x0 is never forwarded
  always_comb begin
    w_fwd_a = (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rs1) ? exmem_result :
              (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rs1) ? memwb_result : r_rs1_val;
    w_fwd_b = (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rs2) ? exmem_result :
              (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rs2) ? memwb_result : r_rs2_val;
  end
  // Capture ID, or load a bubble on reset/flush/stall; source indices clear too so a bubble forwards nothing
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_sel       <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_rs1_val   <= id_rs1_val;
      r_rs2_val   <= id_rs2_val;
      r_imm       <= id_imm;
      r_sel       <= id_alu_sel;
      r_alu_src   <= id_alu_src;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end
  end
  // Saturating count of stall cycles
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign ex_valid      = r_valid;
  assign rd1           = w_fwd_a;
  assign rd2           = r_alu_src ? r_imm : w_fwd_b;
  assign sel           = r_sel;
  assign ex_store_data = w_fwd_b;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign stall_count   = r_cnt;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb_id_ex_forward_stage: directed vector bench for the ID/EX forwarding stage
module tb_id_ex_forward_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic [3:0]  id_alu_sel;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, ex_valid;
  logic [31:0] rd1, rd2, ex_store_data;
  logic [3:0]  sel;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  stall_count;
  int errors = 0;
  int checks = 0;
  id_ex_forward_stage #(.XLEN(32), .REGW(5), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_alu_sel(id_alu_sel),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .stall(stall), .ex_valid(ex_valid), .rd1(rd1), .rd2(rd2), .sel(sel),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] v, rs1, rs2, rd, v1, v2, imm, sel, src, rw, mr, mw, fl;
    logic [31:0] xrd, xw, xres, wrd, ww, wres;
    logic [31:0] e_rd1, e_rd2, e_st, e_sel, e_v, e_rd, e_ctl;
  } vec_t;
  vec_t tv[9];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, logic [31:0] a,
                        logic [31:0] b, logic rw, logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rs1_val = a; id_rs2_val = b;
    id_imm = '0; id_alu_sel = 4'h2; id_alu_src = 1'b0; id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
  endtask
  task automatic chk_out(string n, logic [31:0] e_rd1, logic [31:0] e_rd2, logic [31:0] e_st,
                         logic [31:0] e_sel, logic [31:0] e_v, logic [31:0] e_rd, logic [31:0] e_ctl);
    chk({n, "_rd1"}, rd1, e_rd1);
    chk({n, "_rd2"}, rd2, e_rd2);
    chk({n, "_st"}, ex_store_data, e_st);
    chk({n, "_sel"}, 32'(sel), e_sel);
    chk({n, "_valid"}, 32'(ex_valid), e_v);
    chk({n, "_rd"}, 32'(ex_rd), e_rd);
    chk({n, "_ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), e_ctl);
  endtask
  initial begin
    //        v rs1 rs2 rd  v1  v2  imm          sel src rw mr mw fl  xrd xw xres wrd ww wres  rd1  rd2           st   sel v  rd ctl
    tv[0] = '{1, 1,  2,  3, 122,100,0,           2,  0,  1, 0, 0, 0,  0,  0, 0,   0,  0, 0,    122, 100,          100, 2,  1, 3, 4};
    tv[1] = '{1, 5,  6,  8, 11, 22, 0,           0,  0,  1, 0, 0, 0,  5,  1, 50,  5,  1, 75,   50,  22,           22,  0,  1, 8, 4};
    tv[2] = '{1, 5,  6,  8, 11, 22, 0,           0,  0,  1, 0, 0, 0,  5,  0, 50,  5,  1, 75,   75,  22,           22,  0,  1, 8, 4};
    tv[3] = '{1, 5,  6,  8, 11, 22, 0,           0,  0,  1, 0, 0, 0,  0,  1, 50,  0,  1, 75,   11,  22,           22,  0,  1, 8, 4};
    tv[4] = '{1, 9,  4,  0, 1,  3,  'hFFFF_FFE7, 6,  1,  0, 0, 1, 0,  4,  1, 128, 0,  0, 0,    1,   'hFFFF_FFE7,  128, 6,  1, 0, 1};
    tv[5] = '{1, 3,  3,  10,40, 41, 0,           1,  0,  1, 0, 0, 0,  3,  0, 5,   3,  1, 99,   99,  99,           99,  1,  1, 10,4};
    tv[6] = '{1, 0,  0,  11,7,  8,  0,           2,  0,  1, 0, 0, 0,  0,  1, 5,   0,  1, 6,    7,   8,            8,   2,  1, 11,4};
    tv[7] = '{1, 5,  6,  12,9,  9,  5,           2,  0,  1, 0, 1, 1,  5,  1, 50,  6,  1, 60,   0,   0,            0,   0,  0, 0, 0};
    tv[8] = '{0, 2,  0,  13,33, 44, 0,           1,  0,  0, 0, 0, 0,  0,  0, 0,   0,  0, 0,    33,  44,           44,  1,  0, 13,0};
    reset = 1'b1; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    step; step;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_cnt", 32'(stall_count), 0);
    chk("reset_stall", 32'(stall), 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      id_valid = tv[i].v[0]; id_rs1 = tv[i].rs1[4:0]; id_rs2 = tv[i].rs2[4:0]; id_rd = tv[i].rd[4:0];
      id_rs1_val = tv[i].v1; id_rs2_val = tv[i].v2; id_imm = tv[i].imm; id_alu_sel = tv[i].sel[3:0];
      id_alu_src = tv[i].src[0]; id_reg_write = tv[i].rw[0]; id_mem_read = tv[i].mr[0];
      id_mem_write = tv[i].mw[0]; flush = tv[i].fl[0];
      step;
      flush = 1'b0;
      exmem_rd = tv[i].xrd[4:0]; exmem_reg_write = tv[i].xw[0]; exmem_result = tv[i].xres;
      memwb_rd = tv[i].wrd[4:0]; memwb_reg_write = tv[i].ww[0]; memwb_result = tv[i].wres;
      #1;
      chk_out($sformatf("v%0d", i), tv[i].e_rd1, tv[i].e_rd2, tv[i].e_st, tv[i].e_sel, tv[i].e_v, tv[i].e_rd, tv[i].e_ctl);
    end
    exmem_rd = '0; exmem_reg_write = 1'b0; memwb_rd = '0; memwb_reg_write = 1'b0;
    chk("table_cnt", 32'(stall_count), 0);
    // load-use: load x7 in EX, consumer reads x7 as rs2
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 0, 0, 1'b1, 1'b1);
    step;
    set_id(1'b1, 5'd3, 5'd7, 5'd9, 1, 2, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(stall), 1);
    step;
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_rd1", rd1, 0);
    chk("lu_stall_clear", 32'(stall), 0);
    chk("lu_cnt", 32'(stall_count), 1);
    step;
    memwb_rd = 5'd7; memwb_reg_write = 1'b1; memwb_result = 555;
    #1;
    chk_out("lu_issue", 1, 555, 555, 2, 1, 9, 4);
    chk("lu_issue_stall", 32'(stall), 0);
    memwb_rd = '0; memwb_reg_write = 1'b0;
    // flush beats a pending hazard
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 0, 0, 1'b1, 1'b1);
    step;
    set_id(1'b1, 5'd7, 5'd2, 5'd9, 1, 2, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 0);
    step;
    flush = 1'b0;
    chk_out("fl_bubble", 0, 0, 0, 0, 0, 0, 0);
    chk("fl_cnt", 32'(stall_count), 1);
    // self-dependent load alternates stall/issue; 20 stalls saturate a 4-bit counter
    set_id(1'b1, 5'd7, 5'd0, 5'd7, 3, 0, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) step;
    chk("sat_cnt", 32'(stall_count), 15);
    for (int k = 0; k < 3 && !stall; k++) step;
    chk("mid_stall", 32'(stall), 1);
    reset = 1'b1;
    step;
    chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_cnt", 32'(stall_count), 0);
    chk("rst_mid_stall", 32'(stall), 0);
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
